alu_cmd_sequencer: RTL

//   Initiator side of the ALU operand/result interface. Accepts one command (opcode + two
//   16-bit operands) on a valid/ready port and drives the ALU's s/X/Y inputs. Waits the
//   ALU's fixed pipeline latency, then captures the 32-bit Z and returns it on a

---
 rtl/alu_cmd_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// ============================================================================
// Module   : alu_cmd_sequencer
// Purpose  : Issues one opcode/operand command to a fixed-latency ALU, waits
//            LAT cycles, captures Z and returns it on a valid/ready response port.
//            Optional divide-by-zero short-circuit: define DIV0_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_cmd_sequencer #(
  parameter int LAT   = 3,
  parameter int CNT_W = 8
) (
  input  logic             c,
  input  logic             r,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [15:0]      cmd_x,
  input  logic [15:0]      cmd_y,
  output logic             alu_r,
  output logic [3:0]       alu_s,
  output logic [15:0]      alu_x,
  output logic [15:0]      alu_y,
  input  logic [31:0]      alu_z,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [3:0]       rsp_op,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int WAIT_W = (LAT > 1) ? $clog2(LAT) : 1;

  generate
    if (LAT < 1) begin : g_lat_check
      $error("alu_cmd_sequencer: LAT must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;

`ifdef DIV0_CHECK_EN
  // Set when the in-flight command was short-circuited as a divide by zero.
  logic div0;
`endif

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

`ifndef DIV0_CHECK_EN
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge c) begin
    alu_r <= ~r;
    if (r) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      alu_s     <= '0;
      alu_x     <= '0;
      alu_y     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_op    <= '0;
      done_cnt  <= '0;
`ifdef DIV0_CHECK_EN
      rsp_err   <= 1'b0;
      div0      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            rsp_op <= cmd_op;
            state  <= WAIT;
`ifdef DIV0_CHECK_EN
            if (cmd_op == 4'd3 && cmd_y == 16'd0) begin
              // ALU is left untouched; the error response goes out on the next edge.
              div0     <= 1'b1;
              wait_cnt <= '0;
            end else begin
              div0     <= 1'b0;
              alu_s    <= cmd_op;
              alu_x    <= cmd_x;
              alu_y    <= cmd_y;
              wait_cnt <= WAIT_W'(LAT - 1);
            end
`else
            alu_s    <= cmd_op;
            alu_x    <= cmd_x;
            alu_y    <= cmd_y;
            wait_cnt <= WAIT_W'(LAT - 1);
`endif
          end
        end

        WAIT: begin
          if (wait_cnt == '0) begin
            rsp_valid <= 1'b1;
            state     <= RESP;
`ifdef DIV0_CHECK_EN
            if (div0) begin
              rsp_data <= 32'hFFFF_FFFF;
              rsp_err  <= 1'b1;
            end else begin
              rsp_data <= alu_z;
              rsp_err  <= 1'b0;
            end
`else
            rsp_data <= alu_z;
`endif
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            done_cnt  <= done_cnt + CNT_W'(1);
            state     <= IDLE;
`ifdef DIV0_CHECK_EN
            rsp_err   <= 1'b0;
            div0      <= 1'b0;
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
